// File: rtl/stall_release_ctrl.sv
// Front-end stall/release controller for control-flow hazards: freezes PC and IF/ID until EX resolves.
// Optional watchdog enabled by defining STALL_TIMEOUT_EN.
module stall_release_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 4,
  parameter int MAX_WAIT = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_req,
  input  logic              resolve_valid,
  input  logic              resolve_take,
  input  logic [ADDR_W-1:0] resolve_target,
  output logic              pc_enable,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              if_id_enable,
  output logic              if_id_flush,
  output logic              ctrl_bubble,
  output logic              busy,
  output logic [CNT_W-1:0]  last_stall_cycles,
  output logic [15:0]       stall_total,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    REDIRECT = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_target_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  last_stall_q;
  logic [15:0]       stall_total_q;
  logic              timeout_err_q;

  // The watchdog compares against the saturating wait counter, so the limit must fit in it.
  if (MAX_WAIT < 1 || MAX_WAIT > (2 ** CNT_W) - 1) begin : gBadMaxWait
    $error("stall_release_ctrl: MAX_WAIT must lie in 1 .. 2**CNT_W-1");
  end

`ifdef STALL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WaitLimitM1 = CNT_W'(MAX_WAIT - 1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_target_q   <= '0;
      wait_cnt_q    <= '0;
      last_stall_q  <= '0;
      stall_total_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (stall_req) begin
            state_q    <= WAIT;
            wait_cnt_q <= '0;
          end
        end
        WAIT: begin
          if (wait_cnt_q != CntMax) wait_cnt_q <= wait_cnt_q + 1'b1;
          if (stall_total_q != 16'hFFFF) stall_total_q <= stall_total_q + 16'd1;
          if (resolve_valid) begin
            if (resolve_take) begin
              pc_target_q <= resolve_target;
              state_q     <= REDIRECT;
            end else begin
              state_q <= RELEASE;
            end
          end
`ifdef STALL_TIMEOUT_EN
          // A resolve in the limit cycle wins, so the watchdog only fires without one.
          else if (wait_cnt_q == WaitLimitM1) begin
            state_q       <= RELEASE;
            timeout_err_q <= 1'b1;
          end
`endif
        end
        REDIRECT, RELEASE: begin
          last_stall_q <= wait_cnt_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    pc_enable    = 1'b0;
    pc_sel       = 1'b0;
    if_id_enable = 1'b0;
    if_id_flush  = 1'b0;
    ctrl_bubble  = 1'b1;
    busy         = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          pc_enable    = !stall_req;
          if_id_enable = !stall_req;
          ctrl_bubble  = stall_req;
        end
        WAIT: begin
          busy = 1'b1;
        end
        REDIRECT: begin
          pc_enable    = 1'b1;
          pc_sel       = 1'b1;
          if_id_enable = 1'b1;
          if_id_flush  = 1'b1;
          busy         = 1'b1;
        end
        RELEASE: begin
          pc_enable    = 1'b1;
          if_id_enable = 1'b1;
          busy         = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_target         = pc_target_q;
  assign last_stall_cycles = last_stall_q;
  assign stall_total       = stall_total_q;
`ifdef STALL_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/stall_release_ctrl.md
# stall_release_ctrl

Sequential counterpart to the decode-stage hazard lookup. That lookup raises a stall on J, JAL, JR, BEQ and BNE. This block holds the PC and IF/ID register, and inserts bubbles into ID/EX, until the execute stage resolves the control-flow instruction. It then releases the front end, either redirecting to the resolved target or continuing sequentially. It also keeps stall-cycle statistics for the testbench and performance counters.

## Interface
Parameters:
- ADDR_W, 32, width of PC/target
- CNT_W, 4, width of per-stall cycle counter (saturating)
- MAX_WAIT, 6, WAIT-state cycle limit (used only with STALL_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- stall_req  in  1  decode hazard request; 1 = control-flow instruction in ID (inverse of the lookup's pcEnable)
- resolve_valid  in  1  EX stage has resolved the held instruction this cycle
- resolve_take  in  1  with resolve_valid: 1 = redirect (jump, JR, taken branch)
- resolve_target  in  ADDR_W  redirect address, valid with resolve_valid & resolve_take
- pc_enable  out  1  PC register write enable
- pc_sel  out  1  1 = PC loads pc_target, 0 = PC+4
- pc_target  out  ADDR_W  latched redirect address
- if_id_enable  out  1  IF/ID register write enable
- if_id_flush  out  1  clear IF/ID to NOP on next edge
- ctrl_bubble  out  1  force zero control word into ID/EX
- busy  out  1  state != IDLE
- last_stall_cycles  out  CNT_W  WAIT cycles of most recently completed stall
- stall_total  out  16  total stall cycles since reset, saturating at 16'hFFFF
- timeout_err  out  1  sticky watchdog flag (0 when STALL_TIMEOUT_EN undefined)

## Operation
- States are IDLE, WAIT, REDIRECT and RELEASE. Encoding is free.
- IDLE:
  - pc_enable = if_id_enable = !stall_req.
  - ctrl_bubble = stall_req; pc_sel = 0; if_id_flush = 0.
  - When stall_req = 1, go to WAIT and clear wait_cnt.
- WAIT:
  - pc_enable = 0, if_id_enable = 0, ctrl_bubble = 1.
  - wait_cnt increments each cycle and saturates at 2^CNT_W-1.
  - stall_total increments each cycle and saturates.
  - On resolve_valid with resolve_take = 1: latch resolve_target into pc_target, then go to REDIRECT.
  - On resolve_valid with resolve_take = 0: go to RELEASE.
- REDIRECT:
  - pc_enable = 1, pc_sel = 1, if_id_enable = 1, if_id_flush = 1, ctrl_bubble = 1.
  - Next state is IDLE. last_stall_cycles ← wait_cnt.
- RELEASE:
  - pc_enable = 1, pc_sel = 0, if_id_enable = 1, if_id_flush = 0, ctrl_bubble = 1.
  - Next state is IDLE. last_stall_cycles ← wait_cnt.
- stall_req is ignored outside IDLE, because it reflects the held instruction itself.
- resolve_valid is ignored in IDLE, REDIRECT and RELEASE. This includes the IDLE cycle in which stall_req rises.
- pc_target holds its value until the next take-resolve.

## Timing
- Reset (rst_n = 0 at an edge):
  - state = IDLE; pc_target = 0; wait_cnt = 0; last_stall_cycles = 0; stall_total = 0; timeout_err = 0.
  - While rst_n = 0, outputs are forced: pc_enable = 0, if_id_enable = 0, ctrl_bubble = 1, pc_sel = 0, if_id_flush = 0, busy = 0.
- Reset mid-stall: the next edge returns to IDLE with no redirect and no statistics update.
- The stall takes effect combinationally in the same cycle stall_req rises (Mealy path from IDLE only). All other outputs are decoded from registered state.
- Minimum stall with resolve in the first WAIT cycle:
  - 1 IDLE-stall cycle, 1 WAIT cycle, 1 REDIRECT/RELEASE cycle.
  - PC advances again on the third edge after stall_req rose.
  - last_stall_cycles = 1.
- Back-to-back: stall_req = 1 on the cycle after REDIRECT/RELEASE (IDLE) re-enters WAIT immediately.

## Configuration
- STALL_TIMEOUT_EN defined:
  - If WAIT persists MAX_WAIT cycles without resolve_valid, the next state is RELEASE.
  - timeout_err is set and stays set until reset.
  - A resolve_valid arriving in that same cycle takes priority; no error is raised.
- STALL_TIMEOUT_EN undefined:
  - WAIT persists indefinitely.
  - timeout_err is tied to 0 and no watchdog logic exists.

## Test plan
- Reset: rst_n = 0 for 2 cycles, stall_req = 1 → pc_enable = 0, ctrl_bubble = 1, busy = 0, stall_total = 0, pc_target = 0; after release with stall_req = 0, pc_enable = 1.
- Taken branch: stall_req = 1 at cycle 0; resolve_valid = 1, resolve_take = 1, resolve_target = 32'h0000_0040 at cycle 2 → WAIT for cycles 1–2; cycle 3 shows pc_sel = 1, pc_target = 0x40, if_id_flush = 1; cycle 4 IDLE; last_stall_cycles = 2, stall_total = 2.
- Not-taken branch: resolve at the first WAIT cycle with take = 0 → RELEASE for one cycle with pc_sel = 0, if_id_flush = 0, ctrl_bubble = 1; last_stall_cycles = 1.
- Back-to-back jumps: two stalls each resolved after 1 WAIT cycle, second stall_req asserted the cycle after the first RELEASE → stall_total = 2; second target correctly replaces pc_target.
- Spurious resolve: resolve_valid = 1 in IDLE or REDIRECT → no state change, pc_target unchanged.
- Watchdog (macro on, MAX_WAIT = 6): no resolve → RELEASE after 6 WAIT cycles, timeout_err = 1 and sticky through the next stall. Macro off: busy stays 1 for 20+ cycles and timeout_err = 0.
